alu_share_ctrl: RTL and testbench

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_pkg.sv | 20 ++
 rtl/alu_share_arb.sv | 29 ++
 rtl/alu_share_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared constants for the two-requester ALU sharing controller:
// opcode encodings, FSM state encoding and default datapath sizes.
package alu_share_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OP_W_DEF  = 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t RESP = 2'd2;

endpackage

// File: rtl/alu_share_arb.sv
// Two-way grant selection for the ALU sharing controller.
// Round-robin when ALU_SHARE_RR_EN is defined, fixed priority (req0 first) otherwise.
module alu_share_arb (
  input  logic [1:0] valid,
`ifdef ALU_SHARE_RR_EN
  input  logic       last,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef ALU_SHARE_RR_EN
    // On contention favour whichever requester was not served last.
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
`else
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_SHARE_RR_EN for round-robin arbitration; default is fixed priority.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_v,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_i1,
  output logic [WIDTH-1:0] alu_i2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_cout
);

  state_t           state_reg;
  state_t           state_next;
  logic             gnt_reg;
  logic             err_reg;
  logic [1:0]       grant;
  logic             accept;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_legal;

`ifdef ALU_SHARE_RR_EN
  logic last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (accept) begin
      last_reg <= grant[1];
    end
  end

  alu_share_arb u_arb (
    .valid ( {req1_valid, req0_valid}),
    .last  (last_reg),
    .grant (grant)
  );
`else
  alu_share_arb u_arb (
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );
`endif

  assign req0_ready = (state_reg == IDLE) && grant[0];
  assign req1_ready = (state_reg == IDLE) && grant[1];
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant[1] ? req1_op : req0_op;
  assign sel_a  = grant[1] ? req1_a  : req0_a;
  assign sel_b  = grant[1] ? req1_b  : req0_b;

  assign sel_legal = (sel_op == OP_W'(OP_AND)) || (sel_op == OP_W'(OP_OR)) ||
                     (sel_op == OP_W'(OP_ADD)) || (sel_op == OP_W'(OP_SUB)) ||
                     (sel_op == OP_W'(OP_SLT));

  assign rsp0_valid = (state_reg == RESP) && !gnt_reg;
  assign rsp1_valid = (state_reg == RESP) &&  gnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The alu_* outputs are the latched operands themselves, so they only move on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      gnt_reg    <= 1'b0;
      err_reg    <= 1'b0;
      alu_op     <= '0;
      alu_i1     <= '0;
      alu_i2     <= '0;
      rsp_result <= '0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        gnt_reg <= grant[1];
        err_reg <= !sel_legal;
        alu_op  <= sel_legal ? sel_op : OP_W'(OP_AND);
        alu_i1  <= sel_a;
        alu_i2  <= sel_b;
      end
      // Illegal opcodes still run an AND, but its result and flags are suppressed.
      if (state_reg == EXEC) begin
        rsp_result <= err_reg ? '0 : alu_out;
        rsp_z      <= !err_reg && alu_z;
        rsp_v      <= !err_reg && alu_v;
        rsp_cout   <= !err_reg && alu_cout;
        rsp_err    <= err_reg;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural model of the external ALU.
// Grant-order expectations follow ALU_SHARE_RR_EN when it is defined for the build.
module tb_alu_share_ctrl;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        v;
    logic        c;
    logic        err;
  } res_t;

  typedef struct {
    int          idx;
    res_t        res;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_z, rsp_v, rsp_cout, rsp_err;
  logic [2:0]  alu_op;
  logic [31:0] alu_i1, alu_i2, alu_out;
  logic        alu_z, alu_v, alu_cout;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_acc = 0;
  logic        prev_v = 1'b0;
  exp_t        sb[$];
  int          grants[$];
  logic [31:0] last_res;
  logic        last_z, last_v, last_err;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(32), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_cout(rsp_cout),
    .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_i1(alu_i1), .alu_i2(alu_i2),
    .alu_out(alu_out), .alu_z(alu_z), .alu_v(alu_v), .alu_cout(alu_cout)
  );

  function automatic res_t golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t        o;
    logic [32:0] s;
    o = '0;
    case (op)
      3'b000: o.r = a & b;
      3'b001: o.r = a | b;
      3'b010: begin
        s   = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      3'b110: begin
        s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      3'b111: o.r = {31'd0, ($signed(a) < $signed(b))};
      default: o.err = 1'b1;
    endcase
    o.z = !o.err && (o.r == 32'd0);
    return o;
  endfunction

  // External ALU; an unsupported opcode produces junk so a leak shows up in rsp_*.
  always_comb begin
    res_t m;
    m        = golden(alu_op, alu_i1, alu_i2);
    alu_out  = m.err ? (alu_i1 ^ alu_i2) : m.r;
    alu_z    = m.err ? 1'b1 : m.z;
    alu_v    = m.err ? 1'b1 : m.v;
    alu_cout = m.err ? 1'b1 : m.c;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: push on accept, compare the head while a response is presented, pop on consume.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      prev_v = 1'b0;
    end else begin
      chk("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
      chk("ready_wo_valid", {63'd0, (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)}, 64'd0);
      chk("rsp_excl", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
      if (req0_valid && req0_ready) begin
        e.idx = 0; e.res = golden(req0_op, req0_a, req0_b); e.acc = cyc;
        sb.push_back(e); grants.push_back(0); n_acc++;
      end
      if (req1_valid && req1_ready) begin
        e.idx = 1; e.res = golden(req1_op, req1_a, req1_b); e.acc = cyc;
        sb.push_back(e); grants.push_back(1); n_acc++;
      end
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(sb.size()), 64'd1);
        end else begin
          e = sb[0];
          chk("rsp_idx", {63'd0, rsp1_valid}, 64'(e.idx));
          chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.res.r});
          chk("rsp_flags", {60'd0, rsp_z, rsp_v, rsp_cout, rsp_err},
              {60'd0, e.res.z, e.res.v, e.res.c, e.res.err});
          chk("ready_in_resp", {63'd0, req0_ready | req1_ready}, 64'd0);
          if (!prev_v) chk("latency", 64'(cyc - e.acc), 64'd2);
          if (rsp_ready) begin
            $display("rsp req%0d result=%08h z=%b v=%b c=%b err=%b",
                     e.idx, rsp_result, rsp_z, rsp_v, rsp_cout, rsp_err);
            last_res = rsp_result; last_z = rsp_z; last_v = rsp_v; last_err = rsp_err;
            void'(sb.pop_front());
          end
        end
      end
      prev_v = rsp0_valid | rsp1_valid;
    end
  end

  task automatic set_req(input int p, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Raise valid, wait for the handshake, drop valid just after the accept edge.
  task automatic send(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int t;
    set_req(p, 1'b1, op, a, b);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(p == 0 ? req0_ready : req1_ready) && t < 20);
    chk("accept_timeout", {63'd0, t >= 20}, 64'd0);
    @(posedge clk); #1;
    set_req(p, 1'b0, op, a, b);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || rsp0_valid || rsp1_valid) && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", {63'd0, t >= 40}, 64'd0);
  endtask

  task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    send(p, op, a, b);
    drain();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
    chk("rst_rsp", {28'd0, rsp_result, rsp_z, rsp_v, rsp_cout, rsp_err}, 64'd0);
    chk("rst_alu", {alu_i1, alu_i2}, 64'd0);
    chk("rst_alu_op", {61'd0, alu_op}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    do_reset();

    // Directed arithmetic cases with literal expectations.
    issue(0, 3'b010, 32'h0000_0003, 32'h000F_0F00);
    chk("add_res", {32'd0, last_res}, 64'h000F_0F03);
    chk("add_flags", {61'd0, last_z, last_v, last_err}, 64'd0);
    issue(1, 3'b110, 32'd4, 32'd2);
    chk("sub_res", {32'd0, last_res}, 64'd2);
    chk("sub_z", {63'd0, last_z}, 64'd0);
    issue(1, 3'b111, 32'd2, 32'd4);
    chk("slt_lt", {32'd0, last_res}, 64'd1);
    issue(1, 3'b111, 32'd4, 32'd2);
    chk("slt_ge", {32'd0, last_res}, 64'd0);
    issue(0, 3'b010, 32'h7FFF_FFF0, 32'h7000_F002);
    chk("add_ovf_v", {63'd0, last_v}, 64'd1);
    chk("alu_hold_i1", {32'd0, alu_i1}, 64'h7FFF_FFF0);
    issue(0, 3'b001, 32'h00F0_0000, 32'h0000_000F);
    issue(1, 3'b000, 32'hFF00_FF00, 32'h0F0F_0F0F);
    issue(0, 3'b110, 32'd0, 32'd1);

    // Illegal opcodes: ALU sees AND, response is zero with err set.
    send(0, 3'b011, 32'h0000_00F0, 32'h0000_000F);
    @(negedge clk);
    chk("illegal_alu_op", {61'd0, alu_op}, 64'd0);
    drain();
    chk("illegal_err", {63'd0, last_err}, 64'd1);
    chk("illegal_res", {32'd0, last_res}, 64'd0);
    issue(1, 3'b101, 32'h0000_00FF, 32'h0000_000F);
    issue(0, 3'b100, 32'h1234_5678, 32'hFFFF_FFFF);

    // Back-pressure on the response while requester 1 waits.
    rsp_ready = 1'b0;
    send(0, 3'b001, 32'h0000_1000, 32'h0000_0001);
    set_req(1, 1'b1, 3'b010, 32'd10, 32'd20);
    repeat (6) begin
      @(posedge clk); #1;
      chk("hold_ready1", {63'd0, req1_ready}, 64'd0);
    end
    chk("hold_valid", {63'd0, rsp0_valid}, 64'd1);
    chk("hold_result", {32'd0, rsp_result}, 64'h0000_1001);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", {63'd0, rsp0_valid}, 64'd0);
    chk("waiter_served", {63'd0, req1_ready}, 64'd1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'b010, 32'd10, 32'd20);
    drain();
    chk("waiter_res", {32'd0, last_res}, 64'd30);

    // A request withdrawn before acceptance leaves no trace.
    n0 = n_acc;
    send(0, 3'b010, 32'd1, 32'd1);
    set_req(1, 1'b1, 3'b010, 32'd5, 32'd5);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'b010, 32'd5, 32'd5);
    drain();
    repeat (3) @(posedge clk);
    #1 chk("cancel_accepts", 64'(n_acc - n0), 64'd1);

    // Contention ordering from reset.
    do_reset();
    grants.delete();
    set_req(0, 1'b1, 3'b010, 32'd1, 32'd2);
    set_req(1, 1'b1, 3'b001, 32'h10, 32'h01);
    t = 0;
    while (grants.size() < 4 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("contention_timeout", {63'd0, t >= 60}, 64'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b010, 32'd1, 32'd2);
    set_req(1, 1'b0, 3'b001, 32'h10, 32'h01);
    drain();
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_SHARE_RR_EN
      chk($sformatf("grant%0d", i), 64'((i < grants.size()) ? grants[i] : 9), 64'(i % 2));
`else
      chk($sformatf("grant%0d", i), 64'((i < grants.size()) ? grants[i] : 9), 64'd0);
`endif
    end

    // Reset while an operation is in EXEC.
    send(0, 3'b110, 32'd100, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
    chk("mid_rst_alu", {alu_i1, alu_i2}, 64'd0);
    chk("mid_rst_res", {32'd0, rsp_result}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
    end
    issue(1, 3'b010, 32'd7, 32'd8);
    chk("post_rst_res", {32'd0, last_res}, 64'd15);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
